// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU-to-AXI master bridge: bus widths,
// fixed AXI field encodings and the bridge FSM state type.
package cpu_axi_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = AXI_DATA_BITS / 8;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_RESP_BITS  = 2;

    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } axi_m_state_e;

endpackage

// File: rtl/cpu_axi_if.sv
// AXI bus seen by one CPU master port. Handshake rule on every channel:
// a transfer happens on a rising edge where VALID and READY are both 1;
// the source holds VALID and its payload stable until that edge.
interface cpu_axi_if;
    import cpu_axi_pkg::*;

    // read address channel
    logic [AXI_ID_BITS-1:0]    ARID_M;
    logic [AXI_ADDR_BITS-1:0]  ARADDR_M;
    logic [AXI_LEN_BITS-1:0]   ARLEN_M;
    logic [AXI_SIZE_BITS-1:0]  ARSIZE_M;
    logic [AXI_BURST_BITS-1:0] ARBURST_M;
    logic                      ARVALID_M;
    logic                      ARREADY_M;
    // read data channel
    logic [AXI_ID_BITS-1:0]    RID_M;
    logic [AXI_DATA_BITS-1:0]  RDATA_M;
    logic [AXI_RESP_BITS-1:0]  RRESP_M;
    logic                      RLAST_M;
    logic                      RVALID_M;
    logic                      RREADY_M;
    // write address channel
    logic [AXI_ID_BITS-1:0]    AWID_M;
    logic [AXI_ADDR_BITS-1:0]  AWADDR_M;
    logic [AXI_LEN_BITS-1:0]   AWLEN_M;
    logic [AXI_SIZE_BITS-1:0]  AWSIZE_M;
    logic [AXI_BURST_BITS-1:0] AWBURST_M;
    logic                      AWVALID_M;
    logic                      AWREADY_M;
    // write data channel
    logic [AXI_DATA_BITS-1:0]  WDATA_M;
    logic [AXI_STRB_BITS-1:0]  WSTRB_M;
    logic                      WLAST_M;
    logic                      WVALID_M;
    logic                      WREADY_M;
    // write response channel
    logic [AXI_ID_BITS-1:0]    BID_M;
    logic [AXI_RESP_BITS-1:0]  BRESP_M;
    logic                      BVALID_M;
    logic                      BREADY_M;

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        input  ARREADY_M,
        input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output RREADY_M,
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M
    );

    modport slave (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        output ARREADY_M,
        output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        input  RREADY_M,
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M
    );

endinterface

// File: rtl/cpu_axi_master.sv
// Turns each accepted CPU memory request into one single-beat AXI read
// or write and reports completion, read data and errors back to the CPU.
module cpu_axi_master
    import cpu_axi_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [AXI_ADDR_BITS-1:0] mem_addr,
    input  logic [AXI_DATA_BITS-1:0] mem_wdata,
    input  logic [AXI_STRB_BITS-1:0] mem_wstrb,
    output logic                     mem_ready,
    output logic                     mem_done,
    output logic [AXI_DATA_BITS-1:0] mem_rdata,
    output logic                     mem_err,
    output axi_m_state_e             state,
    cpu_axi_if.master                axi
);

    axi_m_state_e              state_next;
    logic [AXI_ADDR_BITS-1:0]  addr_q;
    logic [AXI_DATA_BITS-1:0]  wdata_q;
    logic [AXI_STRB_BITS-1:0]  wstrb_q;
    logic                      we_q;
    logic                      aw_done;
    logic                      w_done;
    logic                      first_beat;
    logic                      err_q;
    logic                      accept;
    logic                      aw_hs;
    logic                      w_hs;

    // The completion pulse cycle is not idle even though the FSM is back in IDLE.
    assign mem_ready = (state == IDLE) && !mem_done;
    assign accept    = mem_req && mem_ready;
    assign aw_hs     = axi.AWVALID_M && axi.AWREADY_M;
    assign w_hs      = axi.WVALID_M && axi.WREADY_M;

    // Fixed single-beat word transfer fields; payload comes from captured registers.
    assign axi.ARID_M    = MASTER_ID;
    assign axi.ARADDR_M  = addr_q;
    assign axi.ARLEN_M   = '0;
    assign axi.ARSIZE_M  = SIZE_WORD;
    assign axi.ARBURST_M = BURST_INCR;
    assign axi.AWID_M    = MASTER_ID;
    assign axi.AWADDR_M  = addr_q;
    assign axi.AWLEN_M   = '0;
    assign axi.AWSIZE_M  = SIZE_WORD;
    assign axi.AWBURST_M = BURST_INCR;
    assign axi.WDATA_M   = wdata_q;
    assign axi.WSTRB_M   = wstrb_q;
    assign axi.WLAST_M   = 1'b1;

    // Channel handshake outputs decoded from registered state only.
    assign axi.ARVALID_M = (state == RD_ADDR);
    assign axi.RREADY_M  = (state == RD_DATA);
    assign axi.AWVALID_M = (state == WR_REQ) && !aw_done;
    assign axi.WVALID_M  = (state == WR_REQ) && !w_done;
    assign axi.BREADY_M  = (state == WR_RESP);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = mem_we ? WR_REQ : RD_ADDR;
            RD_ADDR: if (axi.ARREADY_M) state_next = RD_DATA;
            RD_DATA: if (axi.RVALID_M && axi.RLAST_M) state_next = IDLE;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (axi.BVALID_M) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, per-channel write tracking, read data and error/completion pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            first_beat <= 1'b0;
            err_q      <= 1'b0;
            mem_rdata  <= '0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= mem_addr;
                        wdata_q    <= mem_wdata;
                        wstrb_q    <= mem_wstrb;
                        we_q       <= mem_we;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        first_beat <= 1'b1;
                        err_q      <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (axi.RVALID_M) begin
                        first_beat <= 1'b0;
                        if (first_beat) mem_rdata <= axi.RDATA_M;
                        if (axi.RLAST_M) begin
                            mem_done <= 1'b1;
                            mem_err  <= err_q || (first_beat && (axi.RRESP_M != RESP_OKAY));
                        end else begin
                            // A multi-beat reply to a single-beat request is malformed.
                            err_q <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (axi.BVALID_M) begin
                        mem_done <= 1'b1;
                        mem_err  <= err_q || (axi.BRESP_M != RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master with the AXI slave side driven by hand.
module tb_cpu_axi_master;
    import cpu_axi_pkg::*;

    logic         aclk = 1'b0;
    logic         areset;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic         mem_done;
    logic [31:0]  mem_rdata;
    logic         mem_err;
    axi_m_state_e state;

    int vectors     = 0;
    int miscompares = 0;

    cpu_axi_if bus ();

    cpu_axi_master #(.MASTER_ID(4'd0)) dut (
        .ACLK      (aclk),
        .ARESET    (areset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .state     (state),
        .axi       (bus.master)
    );

    always #5 aclk = ~aclk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, " arvalid"}, {31'd0, bus.ARVALID_M}, 32'd0);
        check({tag, " rready"},  {31'd0, bus.RREADY_M},  32'd0);
        check({tag, " awvalid"}, {31'd0, bus.AWVALID_M}, 32'd0);
        check({tag, " wvalid"},  {31'd0, bus.WVALID_M},  32'd0);
        check({tag, " bready"},  {31'd0, bus.BREADY_M},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        areset = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        bus.ARREADY_M = 1'b0;
        bus.RID_M = '0; bus.RDATA_M = '0; bus.RRESP_M = '0; bus.RLAST_M = 1'b0; bus.RVALID_M = 1'b0;
        bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0;
        bus.BID_M = '0; bus.BRESP_M = '0; bus.BVALID_M = 1'b0;

        // Reset state
        tick(); tick();
        check_idle_bus("reset");
        check("reset mem_done",  {31'd0, mem_done},  32'd0);
        check("reset mem_err",   {31'd0, mem_err},   32'd0);
        check("reset mem_rdata", mem_rdata,          32'd0);
        check("reset mem_ready", {31'd0, mem_ready}, 32'd1);
        check("reset state",     {29'd0, state},     32'd0);
        areset = 1'b0;
        tick();

        // 1: read, slave ready at once
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1004;
        check("t1 ready at accept", {31'd0, mem_ready}, 32'd1);
        tick();
        mem_req = 1'b0;
        check("t1 arvalid",  {31'd0, bus.ARVALID_M}, 32'd1);
        check("t1 araddr",   bus.ARADDR_M,           32'h0000_1004);
        check("t1 arlen",    {28'd0, bus.ARLEN_M},   32'd0);
        check("t1 arsize",   {29'd0, bus.ARSIZE_M},  32'd2);
        check("t1 arburst",  {30'd0, bus.ARBURST_M}, 32'd1);
        check("t1 arid",     {28'd0, bus.ARID_M},    32'd0);
        check("t1 busy",     {31'd0, mem_ready},     32'd0);
        bus.ARREADY_M = 1'b1;
        tick();
        bus.ARREADY_M = 1'b0;
        check("t1 ar dropped", {31'd0, bus.ARVALID_M}, 32'd0);
        check("t1 rready",     {31'd0, bus.RREADY_M},  32'd1);
        check("t1 no early done", {31'd0, mem_done},   32'd0);
        bus.RVALID_M = 1'b1; bus.RDATA_M = 32'hDEAD_BEEF; bus.RLAST_M = 1'b1; bus.RRESP_M = 2'b00;
        tick();
        bus.RVALID_M = 1'b0; bus.RLAST_M = 1'b0;
        check("t1 done",       {31'd0, mem_done},  32'd1);
        check("t1 rdata",      mem_rdata,          32'hDEAD_BEEF);
        check("t1 err",        {31'd0, mem_err},   32'd0);
        check("t1 ready in done", {31'd0, mem_ready}, 32'd0);
        check("t1 rready off", {31'd0, bus.RREADY_M}, 32'd0);
        tick();
        check("t1 done pulse", {31'd0, mem_done},  32'd0);
        check("t1 ready back", {31'd0, mem_ready}, 32'd1);

        // 2: write, AW and W accepted in the same cycle
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_2000;
        mem_wdata = 32'h1234_5678; mem_wstrb = 4'b0011;
        tick();
        mem_req = 1'b0;
        check("t2 awvalid", {31'd0, bus.AWVALID_M}, 32'd1);
        check("t2 wvalid",  {31'd0, bus.WVALID_M},  32'd1);
        check("t2 awaddr",  bus.AWADDR_M,           32'h0000_2000);
        check("t2 wdata",   bus.WDATA_M,            32'h1234_5678);
        check("t2 wstrb",   {28'd0, bus.WSTRB_M},   32'h3);
        check("t2 wlast",   {31'd0, bus.WLAST_M},   32'd1);
        check("t2 awsize",  {29'd0, bus.AWSIZE_M},  32'd2);
        check("t2 bready early", {31'd0, bus.BREADY_M}, 32'd0);
        bus.AWREADY_M = 1'b1; bus.WREADY_M = 1'b1;
        tick();
        bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0;
        check("t2 aw dropped", {31'd0, bus.AWVALID_M}, 32'd0);
        check("t2 w dropped",  {31'd0, bus.WVALID_M},  32'd0);
        check("t2 bready",     {31'd0, bus.BREADY_M},  32'd1);
        bus.BVALID_M = 1'b1; bus.BRESP_M = 2'b00;
        tick();
        bus.BVALID_M = 1'b0;
        check("t2 done", {31'd0, mem_done}, 32'd1);
        check("t2 err",  {31'd0, mem_err},  32'd0);
        check("t2 bready off", {31'd0, bus.BREADY_M}, 32'd0);
        tick();
        check("t2 done pulse", {31'd0, mem_done}, 32'd0);

        // 3: write, W ready 4 cycles after AW, SLVERR response
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_3000;
        mem_wdata = 32'hA5A5_0F0F; mem_wstrb = 4'b1111;
        tick();
        mem_req = 1'b0; mem_wdata = 32'h0;
        bus.AWREADY_M = 1'b1;
        tick();
        bus.AWREADY_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3 aw low",  {31'd0, bus.AWVALID_M}, 32'd0);
            check("t3 w held",  {31'd0, bus.WVALID_M},  32'd1);
            check("t3 wdata",   bus.WDATA_M,            32'hA5A5_0F0F);
            check("t3 no bready", {31'd0, bus.BREADY_M}, 32'd0);
            tick();
        end
        check("t3 w held last", {31'd0, bus.WVALID_M}, 32'd1);
        bus.WREADY_M = 1'b1;
        tick();
        bus.WREADY_M = 1'b0;
        check("t3 w dropped", {31'd0, bus.WVALID_M}, 32'd0);
        check("t3 bready",    {31'd0, bus.BREADY_M}, 32'd1);
        bus.BVALID_M = 1'b1; bus.BRESP_M = 2'b10;
        tick();
        bus.BVALID_M = 1'b0; bus.BRESP_M = 2'b00;
        check("t3 done", {31'd0, mem_done}, 32'd1);
        check("t3 err",  {31'd0, mem_err},  32'd1);
        tick();
        check("t3 err pulse", {31'd0, mem_err}, 32'd0);

        // 4: read, ARREADY stalled 5 cycles, SLVERR; a held request and changing addr are ignored
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_4008;
        tick();
        mem_we = 1'b1; mem_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check("t4 arvalid held", {31'd0, bus.ARVALID_M}, 32'd1);
            check("t4 araddr stable", bus.ARADDR_M,          32'h0000_4008);
            check("t4 no awvalid",   {31'd0, bus.AWVALID_M}, 32'd0);
            check("t4 state",        {29'd0, state},         32'd1);
            tick();
        end
        mem_req = 1'b0;
        bus.ARREADY_M = 1'b1;
        tick();
        bus.ARREADY_M = 1'b0;
        check("t4 rready", {31'd0, bus.RREADY_M}, 32'd1);
        tick();
        check("t4 wait rvalid", {31'd0, mem_done}, 32'd0);
        bus.RVALID_M = 1'b1; bus.RDATA_M = 32'h0BAD_F00D; bus.RRESP_M = 2'b10; bus.RLAST_M = 1'b1;
        tick();
        bus.RVALID_M = 1'b0; bus.RRESP_M = 2'b00; bus.RLAST_M = 1'b0;
        check("t4 done",  {31'd0, mem_done}, 32'd1);
        check("t4 err",   {31'd0, mem_err},  32'd1);
        check("t4 rdata", mem_rdata,         32'h0BAD_F00D);
        tick();
        check("t4 done pulse", {31'd0, mem_done}, 32'd0);
        check("t4 err pulse",  {31'd0, mem_err},  32'd0);
        check("t4 rdata held", mem_rdata,         32'h0BAD_F00D);

        // 5: malformed 2-beat read burst
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_5000;
        tick();
        mem_req = 1'b0;
        bus.ARREADY_M = 1'b1;
        tick();
        bus.ARREADY_M = 1'b0;
        bus.RVALID_M = 1'b1; bus.RDATA_M = 32'h1111_2222; bus.RLAST_M = 1'b0;
        tick();
        check("t5 no done on beat0", {31'd0, mem_done},     32'd0);
        check("t5 still draining",   {31'd0, bus.RREADY_M}, 32'd1);
        bus.RDATA_M = 32'h3333_4444; bus.RLAST_M = 1'b1;
        tick();
        bus.RVALID_M = 1'b0; bus.RLAST_M = 1'b0;
        check("t5 done",  {31'd0, mem_done}, 32'd1);
        check("t5 err",   {31'd0, mem_err},  32'd1);
        check("t5 rdata", mem_rdata,         32'h1111_2222);
        tick();
        check("t5 single done", {31'd0, mem_done}, 32'd0);

        // 6: reset in RD_DATA, then a normal read
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_6000;
        tick();
        mem_req = 1'b0;
        bus.ARREADY_M = 1'b1;
        tick();
        bus.ARREADY_M = 1'b0;
        check("t6 in rd_data", {29'd0, state}, 32'd2);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_idle_bus("t6 after reset");
        check("t6 ready",   {31'd0, mem_ready}, 32'd1);
        check("t6 no done", {31'd0, mem_done},  32'd0);
        tick();
        check("t6 no late done", {31'd0, mem_done}, 32'd0);
        mem_req = 1'b1; mem_addr = 32'h0000_6004;
        tick();
        mem_req = 1'b0;
        check("t6 araddr", bus.ARADDR_M, 32'h0000_6004);
        bus.ARREADY_M = 1'b1;
        tick();
        bus.ARREADY_M = 1'b0;
        bus.RVALID_M = 1'b1; bus.RDATA_M = 32'hCAFE_F00D; bus.RLAST_M = 1'b1;
        tick();
        bus.RVALID_M = 1'b0; bus.RLAST_M = 1'b0;
        check("t6 done",  {31'd0, mem_done}, 32'd1);
        check("t6 err",   {31'd0, mem_err},  32'd0);
        check("t6 rdata", mem_rdata,         32'hCAFE_F00D);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
